frame_receiver: RTL and testbench
=================================

Name: frame_receiver

Overview:
- Consumes the serialized pixel stream produced by the rasterizer: a one-cycle frame_sync, followed by 64 pixels in row-major order, one pixel per cycle.
- Captures the stream into a shadow buffer and atomically commits the complete frame to a display buffer.
- Drives a row-multiplexed 8x8 LED matrix from the display buffer, and provides a combinational row-readback port for debug and test.

Parameters:
- SCAN_DIV, 16, clock cycles each matrix row is held before the scan advances (legal range 1..65535).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- frame_sync  in  1  start-of-frame strobe from the rasterizer
- pixel_in  in  4  pixel from the rasterizer; only bit 0 is used, bits 3:1 are ignored
- rd_row  in  3  readback row select
- rd_data  out  8  display_buf[rd_row], combinational; bit x = pixel (x, rd_row)
- row_sel  out  8  one-hot row drive, active-high, registered
- col_data  out  8  column drive for the active row, registered; bit x = pixel (x, row)
- frame_done  out  1  one-cycle pulse after a frame commits
- frame_err  out  1  one-cycle pulse after a truncated frame is aborted
- busy  out  1  high while in CAPTURE
- frame_cnt  out  8  count of committed frames, wraps 255 -> 0

Behaviour:
- Reset (rst high at a clock edge):
  - state=IDLE, pix_cnt=0.
  - shadow_buf and display_buf cleared to all zero.
  - row_idx=0, scan_cnt=0, row_sel=8'h01, col_data=8'h00.
  - frame_done=0, frame_err=0, busy=0, frame_cnt=0.
  - Reset mid-capture discards the partial frame with no err/done pulse.
- Stream timing:
  - E0 = the edge that samples frame_sync=1.
  - Pixel k (k=0..63) is sampled at edge E(k+1).
  - x = k[2:0], y = k[5:3]; the bit is written to shadow_buf[y][x].
- FSM:
  - IDLE: frame_sync=1 -> CAPTURE with pix_cnt=0. Otherwise stay; pixel_in is ignored.
  - CAPTURE, frame_sync=0: store pixel_in[0] at pix_cnt, then pix_cnt+1.
  - At pix_cnt=63, on the same edge:
    - display_buf <= shadow_buf with pixel 63 merged in (no stale bit).
    - frame_cnt+1.
    - frame_done=1 in the next cycle.
    - state -> IDLE.
  - CAPTURE, frame_sync=1 with pix_cnt<63: abort the frame (the pixel is not stored), frame_err=1 in the next cycle, pix_cnt=0, stay in CAPTURE. display_buf is unchanged.
  - CAPTURE, frame_sync=1 with pix_cnt=63: pixel 63 is stored, the frame commits normally (done, no err), and the next capture starts (state stays CAPTURE, pix_cnt=0).
- Shadow buffer: not cleared between frames; every location is overwritten by a full frame.
- busy: high exactly while state=CAPTURE, registered.
- Scan:
  - scan_cnt counts 0..SCAN_DIV-1 continuously, independent of capture.
  - On wrap: row_idx+1 (7 wraps to 0), row_sel=1<<row_idx_next, col_data=display_buf[row_idx_next]; row_sel and col_data update on the same edge.
  - A commit becomes visible on col_data at the next row advance. rd_data reflects it right after the commit edge.
- Widths: pix_cnt 6 bits, scan_cnt 16 bits, frame_cnt 8 bits modulo; no saturation anywhere.

Test Plan:
1. Reset, then idle 2*8*SCAN_DIV cycles -> row_sel walks 01,02,..,80,01 every SCAN_DIV cycles; col_data=00; frame_done, frame_err, busy all stay 0.
2. frame_sync, then 64 pixels with only k=0 and k=63 set -> busy high for 64 cycles; frame_done pulses once; rd_row=0 gives 8'h01, rd_row=7 gives 8'h80, others 00; frame_cnt=1; while row_sel=80, col_data=80.
3. frame_sync, 20 pixels, then frame_sync again, then 64 pixels of all 1s -> frame_err pulses once; display_buf unchanged until the full frame commits; then rd_data=FF for every row; frame_cnt+1 only once.
4. Two back-to-back frames, with the second frame_sync coincident with pixel 63 of the first -> two frame_done pulses, no frame_err; display_buf equals the second frame; frame_cnt+2.
5. rst asserted at pixel 30 of a frame, then released -> display_buf=0, frame_cnt=0, busy=0, no pulses; a following full frame captures correctly.
6. 256 complete frames -> frame_cnt wraps to 0; frame_done pulses 256 times.

Source files
------------

// File: rtl/frame_receiver.sv
// Receives the rasterizer's 64-pixel stream into a shadow buffer and commits each
// complete frame to a display buffer. The display buffer is row-scanned onto an 8x8 LED matrix.
module frame_receiver #(
  parameter int unsigned SCAN_DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_sync,
  input  logic [3:0] pixel_in,
  input  logic [2:0] rd_row,
  output logic [7:0] rd_data,
  output logic [7:0] row_sel,
  output logic [7:0] col_data,
  output logic       frame_done,
  output logic       frame_err,
  output logic       busy,
  output logic [7:0] frame_cnt
);

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_CAPTURE = 1'b1
  } state_t;

  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

  // Capture side
  state_t          r_state;
  logic [5:0]      r_pix_cnt;
  logic [7:0][7:0] r_shadow;
  logic [7:0][7:0] r_display;
  logic            r_frame_done;
  logic            r_frame_err;
  logic            r_busy;
  logic [7:0]      r_frame_cnt;

  // Scan side
  logic [15:0]     r_scan_cnt;
  logic [2:0]      r_row_idx;
  logic [7:0]      r_row_sel;
  logic [7:0]      r_col_data;

  logic            w_pix;
  logic            w_unused;
  logic [2:0]      w_x;
  logic [2:0]      w_y;
  logic            w_last;
  logic [7:0][7:0] w_commit;
  logic            w_scan_wrap;
  logic [2:0]      w_row_next;

  assign w_pix    = pixel_in[0];
  assign w_unused = ^pixel_in[3:1];
  assign w_x      = r_pix_cnt[2:0];
  assign w_y      = r_pix_cnt[5:3];
  assign w_last   = (r_pix_cnt == 6'd63);

  // The committed frame must include pixel 63, which lands in the shadow on the same edge.
  always_comb begin
    // NOTE: assign a full default before any partial update so no bit is left to hold its old value (latch).
    w_commit       = r_shadow;
    w_commit[7][7] = w_pix;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pix_cnt    <= '0;
      // NOTE: both buffers are plain flop arrays, not RAM macros, so clearing them in reset is legal and cheap to express.
      r_shadow     <= '0;
      r_display    <= '0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      // NOTE: non-blocking assignments everywhere in sequential logic; every read sees the pre-edge value.
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (frame_sync) begin
            r_state   <= S_CAPTURE;
            r_busy    <= 1'b1;
            r_pix_cnt <= '0;
          end
        end
        S_CAPTURE: begin
          if (w_last) begin
            r_shadow[w_y][w_x] <= w_pix;
            r_display          <= w_commit;
            r_frame_cnt        <= r_frame_cnt + 8'd1;
            r_frame_done       <= 1'b1;
            r_pix_cnt          <= '0;
            // A sync coincident with pixel 63 opens the next frame straight away.
            if (!frame_sync) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else if (frame_sync) begin
            r_frame_err <= 1'b1;
            r_pix_cnt   <= '0;
          end else begin
            r_shadow[w_y][w_x] <= w_pix;
            r_pix_cnt          <= r_pix_cnt + 6'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign w_scan_wrap = (r_scan_cnt == SCAN_LAST);
  assign w_row_next  = r_row_idx + 3'd1;

  // The scan runs freely; a new frame shows up on col_data at the next row advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan_cnt <= '0;
      r_row_idx  <= '0;
      r_row_sel  <= 8'h01;
      r_col_data <= 8'h00;
    end else if (w_scan_wrap) begin
      r_scan_cnt <= '0;
      r_row_idx  <= w_row_next;
      r_row_sel  <= 8'd1 << w_row_next;
      r_col_data <= r_display[w_row_next];
    end else begin
      r_scan_cnt <= r_scan_cnt + 16'd1;
    end
  end

  assign rd_data    = r_display[rd_row];
  assign row_sel    = r_row_sel;
  assign col_data   = r_col_data;
  assign frame_done = r_frame_done;
  assign frame_err  = r_frame_err;
  assign busy       = r_busy;
  assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_frame_receiver.sv
// Directed testbench for frame_receiver. Frames are 64-bit vectors: bit k = pixel k,
// so row y is frame[8*y +: 8].
module tb_frame_receiver;

  localparam int unsigned SCAN_DIV = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_sync;
  logic [3:0] pixel_in;
  logic [2:0] rd_row;
  logic [7:0] rd_data;
  logic [7:0] row_sel;
  logic [7:0] col_data;
  logic       frame_done;
  logic       frame_err;
  logic       busy;
  logic [7:0] frame_cnt;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int busy_cyc = 0;

  frame_receiver #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .frame_sync(frame_sync),
    .pixel_in  (pixel_in),
    .rd_row    (rd_row),
    .rd_data   (rd_data),
    .row_sel   (row_sel),
    .col_data  (col_data),
    .frame_done(frame_done),
    .frame_err (frame_err),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (frame_err)  err_cnt++;
    if (busy)       busy_cyc++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic send_sync();
    frame_sync = 1'b1;
    pixel_in   = 4'b1010;
    tick();
    frame_sync = 1'b0;
  endtask

  // Sends pixels first..first+n-1; upper pixel bits carry junk that must be ignored.
  task automatic send_pixels(input logic [63:0] frame, input int first, input int n,
                             input bit sync_on_last);
    for (int k = first; k < first + n; k++) begin
      pixel_in   = {3'b101, frame[k]};
      frame_sync = sync_on_last && (k == first + n - 1);
      tick();
    end
    frame_sync = 1'b0;
    pixel_in   = 4'b0000;
  endtask

  task automatic check_frame(input string tag, input logic [63:0] frame);
    for (int y = 0; y < 8; y++) begin
      rd_row = 3'(y);
      #1;
      check($sformatf("%s row%0d", tag, y), rd_data, frame[8*y +: 8]);
    end
  endtask

  // Waits for a fresh arrival of row_sel==want so col_data reflects the latest commit.
  task automatic wait_row(input logic [7:0] want, input string tag);
    int n = 0;
    while (row_sel == want && n < 3 * 8 * SCAN_DIV) begin tick(); n++; end
    while (row_sel != want && n < 3 * 8 * SCAN_DIV) begin tick(); n++; end
    check(tag, row_sel, want);
  endtask

  initial begin
    logic [63:0] f_a, f_b, f_c, f_d, f_last;
    int d0, e0, b0;

    rst = 1'b1; frame_sync = 1'b0; pixel_in = 4'b0000; rd_row = 3'd0;
    tick(); tick();
    rst = 1'b0;

    // 1: reset state and idle row scan
    do_reset();
    check("rst frame_cnt", frame_cnt, 8'h00);
    check("rst busy", busy, 1'b0);
    check_frame("rst display", 64'h0);
    d0 = done_cnt; e0 = err_cnt; b0 = busy_cyc;
    for (int r = 0; r <= 16; r++) begin
      check($sformatf("scan row_sel r%0d", r), row_sel, 8'h01 << (r % 8));
      check($sformatf("scan col_data r%0d", r), col_data, 8'h00);
      if (r < 16) begin
        repeat (SCAN_DIV - 1) tick();
        check($sformatf("scan hold r%0d", r), row_sel, 8'h01 << (r % 8));
        tick();
      end
    end
    check("idle done pulses", done_cnt - d0, 0);
    check("idle err pulses", err_cnt - e0, 0);
    check("idle busy cycles", busy_cyc - b0, 0);

    // 2: one frame with only the corner pixels set
    f_a = 64'h8000_0000_0000_0001;
    d0 = done_cnt; b0 = busy_cyc;
    send_sync();
    check("t2 busy after sync", busy, 1'b1);
    send_pixels(f_a, 0, 64, 1'b0);
    check("t2 done pulse", frame_done, 1'b1);
    check("t2 busy cleared", busy, 1'b0);
    check("t2 busy cycles", busy_cyc - b0, 64);
    tick();
    check("t2 done one cycle", frame_done, 1'b0);
    check("t2 done count", done_cnt - d0, 1);
    check("t2 frame_cnt", frame_cnt, 8'd1);
    check_frame("t2 display", f_a);
    wait_row(8'h80, "t2 reach row7");
    check("t2 col_data row7", col_data, 8'h80);
    wait_row(8'h01, "t2 reach row0");
    check("t2 col_data row0", col_data, 8'h01);

    // 3: truncated frame aborted by an early sync, then a full all-ones frame
    f_b = 64'hFFFF_FFFF_FFFF_FFFF;
    d0 = done_cnt; e0 = err_cnt;
    send_sync();
    send_pixels(f_b, 0, 20, 1'b0);
    send_sync();
    check("t3 err pulse", frame_err, 1'b1);
    check("t3 still busy", busy, 1'b1);
    send_pixels(f_b, 0, 63, 1'b0);
    check("t3 err count", err_cnt - e0, 1);
    check_frame("t3 display held", f_a);
    send_pixels(f_b, 63, 1, 1'b0);
    check("t3 done pulse", frame_done, 1'b1);
    tick();
    check("t3 done count", done_cnt - d0, 1);
    check("t3 err count final", err_cnt - e0, 1);
    check("t3 frame_cnt", frame_cnt, 8'd2);
    check_frame("t3 display", f_b);

    // 4: back-to-back frames, second sync on pixel 63 of the first
    f_c = 64'h5AA5_3CC3_0FF0_A55A;
    f_d = 64'h0123_4567_89AB_CDEF;
    d0 = done_cnt; e0 = err_cnt;
    send_sync();
    send_pixels(f_c, 0, 64, 1'b1);
    check("t4 first done", frame_done, 1'b1);
    check("t4 busy between", busy, 1'b1);
    rd_row = 3'd3;
    #1;
    check("t4 first committed row3", rd_data, f_c[31:24]);
    send_pixels(f_d, 0, 64, 1'b0);
    check("t4 second done", frame_done, 1'b1);
    tick();
    check("t4 done count", done_cnt - d0, 2);
    check("t4 err count", err_cnt - e0, 0);
    check("t4 frame_cnt", frame_cnt, 8'd4);
    check("t4 busy end", busy, 1'b0);
    check_frame("t4 display", f_d);

    // 5: reset in the middle of a frame, then a clean frame
    d0 = done_cnt; e0 = err_cnt;
    send_sync();
    send_pixels(f_c, 0, 30, 1'b0);
    rst = 1'b1;
    pixel_in = {3'b000, f_c[30]};
    tick();
    rst = 1'b0;
    pixel_in = 4'b0000;
    check("t5 busy", busy, 1'b0);
    check("t5 frame_cnt", frame_cnt, 8'd0);
    check("t5 row_sel", row_sel, 8'h01);
    check("t5 col_data", col_data, 8'h00);
    check_frame("t5 display cleared", 64'h0);
    tick(); tick();
    check("t5 no done", done_cnt - d0, 0);
    check("t5 no err", err_cnt - e0, 0);
    send_sync();
    send_pixels(f_c, 0, 64, 1'b0);
    tick();
    check("t5 frame_cnt after", frame_cnt, 8'd1);
    check_frame("t5 display", f_c);

    // 6: 256 complete frames wrap frame_cnt
    do_reset();
    d0 = done_cnt;
    f_last = 64'h0;
    for (int i = 0; i < 256; i++) begin
      f_last = f_d ^ {8{8'(i)}};
      send_sync();
      send_pixels(f_last, 0, 64, 1'b0);
      if (i == 254) check("t6 frame_cnt 255", frame_cnt, 8'd255);
    end
    tick();
    check("t6 frame_cnt wrap", frame_cnt, 8'd0);
    check("t6 done count", done_cnt - d0, 256);
    check_frame("t6 display", f_last);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
